// File: rtl/cpu8_pkg.sv
// Shared constants for the 8-bit CPU slice: FSM state encoding, requester
// port IDs and default bus widths.
package cpu8_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: lone requester wins; ties go to port 0 under
// fixed priority, otherwise to the port that was not granted last.
module rr_arb2
  import cpu8_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic win_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    win_o   = PORT_CPU;
    if (req0_i && req1_i) begin
      if (FIXED_PRIO) begin
        win_o = PORT_CPU;
      end else begin
        win_o = ~last_gnt_i;
      end
    end else if (req1_i) begin
      win_o = PORT_DMA;
    end else begin
      win_o = PORT_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between a CPU port (0) and a DMA port (1); one
// access at a time through IDLE -> ISSUE -> RESP, with a req/ack handshake.
module ram_arbiter
  import cpu8_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_re,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_gnt_q, last_gnt_d;
  logic            cmd_we_q, cmd_we_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic            arb_win;
  logic            arb_valid;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req0_i     (p0_req),
    .req1_i     (p1_req),
    .last_gnt_i (last_gnt_q),
    .win_o      (arb_win),
    .valid_o    (arb_valid)
  );

  // last_gnt resets to the DMA port so the first tie goes to the CPU
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= PORT_CPU;
      last_gnt_q  <= PORT_DMA;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d     = ST_ISSUE;
          gnt_d       = arb_win;
          last_gnt_d  = arb_win;
          cmd_we_d    = arb_win ? p1_we    : p0_we;
          cmd_addr_d  = arb_win ? p1_addr  : p0_addr;
          cmd_wdata_d = arb_win ? p1_wdata : p0_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM strobes only in ISSUE; read data is already registered by the RAM
  always_comb begin
    ram_addr  = cmd_addr_q;
    ram_wdata = cmd_wdata_q;
    ram_we    = (state_q == ST_ISSUE) &  cmd_we_q;
    ram_re    = (state_q == ST_ISSUE) & ~cmd_we_q;
    busy      = (state_q == ST_ISSUE) | (state_q == ST_RESP);
    p0_ack    = (state_q == ST_RESP) & (gnt_q == PORT_CPU);
    p1_ack    = (state_q == ST_RESP) & (gnt_q == PORT_DMA);
    p0_rdata  = ram_rdata;
    p1_rdata  = ram_rdata;
  end

endmodule
